// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, opcode/funct values,
// datapath select codes and the decoded instruction class.
package mc_pkg;

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StExe  = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpHalt  = 6'b111111;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluAnd = 3'd2;
  localparam logic [2:0] AluOr  = 3'd3;
  localparam logic [2:0] AluSlt = 3'd4;

  localparam logic [1:0] PcAlu   = 2'd0;
  localparam logic [1:0] PcCache = 2'd1;
  localparam logic [1:0] PcJump  = 2'd2;

  localparam logic [1:0] SrcBReg   = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  typedef struct packed {
    logic rtype;
    logic imm_arith;
    logic is_ori;
    logic load;
    logic store;
    logic branch;
    logic is_bne;
    logic jump;
    logic halt;
    logic illegal;
  } insn_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decode into an instruction class and the R-type ALU operation.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output insn_class_t cls,
  output logic [2:0]  rtype_op
);

  always_comb begin
    cls = '0;
    case (opcode)
      OpRtype: cls.rtype = 1'b1;
      OpAddi:  cls.imm_arith = 1'b1;
      OpOri: begin
        cls.imm_arith = 1'b1;
        cls.is_ori    = 1'b1;
      end
      OpLw:    cls.load = 1'b1;
      OpSw:    cls.store = 1'b1;
      OpBeq:   cls.branch = 1'b1;
      OpBne: begin
        cls.branch = 1'b1;
        cls.is_bne = 1'b1;
      end
      OpJ:     cls.jump = 1'b1;
      OpHalt:  cls.halt = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

  // Unrecognised funct codes fall back to add.
  always_comb begin
    case (funct)
      FnSub:   rtype_op = AluSub;
      FnAnd:   rtype_op = AluAnd;
      FnOr:    rtype_op = AluOr;
      FnSlt:   rtype_op = AluSlt;
      default: rtype_op = AluAdd;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer with a memory-handshake watchdog that halts
// the core when a strobe is held too long without mem_ready.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_we,
  output logic       ab_we,
  output logic       alu_cache_we,
  output logic       mdr_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       illegal_op,
  output logic       halted,
  output logic       mem_fault,
  output logic [2:0] state
);

  localparam int unsigned WdW = $clog2(WAIT_MAX + 1);

  state_e         state_q, state_d;
  logic [WdW-1:0] wdog_q, wdog_d, wdog_inc;
  logic           halted_q, fault_q;
  logic           timeout, strobe;
  insn_class_t    cls;
  logic [2:0]     rtype_op;

  mc_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .cls      (cls),
    .rtype_op (rtype_op)
  );

  assign wdog_inc = wdog_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    ir_we        = 1'b0;
    ab_we        = 1'b0;
    alu_cache_we = 1'b0;
    mdr_we       = 1'b0;
    pc_we        = 1'b0;
    reg_we       = 1'b0;
    pc_src       = PcAlu;
    alu_src_a    = 1'b0;
    alu_src_b    = SrcBReg;
    alu_op       = AluAdd;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    illegal_op   = 1'b0;
    timeout      = 1'b0;
    // Outputs are held quiet while reset is asserted so strobes drop immediately.
    if (!rst) begin
      case (state_q)
        StIf: begin
          mem_rd    = 1'b1;
          alu_src_b = SrcBFour;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = StId;
          end
        end
        StId: begin
          ab_we        = 1'b1;
          alu_cache_we = 1'b1;
          alu_src_b    = SrcBImmSh;
          if (cls.halt) begin
            state_d = StHalt;
          end else if (cls.illegal) begin
            illegal_op = 1'b1;
            state_d    = StIf;
          end else begin
            state_d = StExe;
          end
        end
        StExe: begin
          state_d = StIf;
          if (cls.rtype) begin
            alu_src_a    = 1'b1;
            alu_op       = rtype_op;
            alu_cache_we = 1'b1;
            state_d      = StWb;
          end else if (cls.imm_arith) begin
            alu_src_a    = 1'b1;
            alu_src_b    = SrcBImm;
            alu_op       = cls.is_ori ? AluOr : AluAdd;
            alu_cache_we = 1'b1;
            state_d      = StWb;
          end else if (cls.load || cls.store) begin
            alu_src_a    = 1'b1;
            alu_src_b    = SrcBImm;
            alu_cache_we = 1'b1;
            state_d      = StMem;
          end else if (cls.branch) begin
            alu_src_a = 1'b1;
            alu_op    = AluSub;
            pc_src    = PcCache;
            pc_we     = cls.is_bne ? !zero : zero;
          end else if (cls.jump) begin
            pc_we  = 1'b1;
            pc_src = PcJump;
          end
        end
        StMem: begin
          state_d = StIf;
          if (cls.load) begin
            mem_rd  = 1'b1;
            state_d = StMem;
            if (mem_ready) begin
              mdr_we  = 1'b1;
              state_d = StWb;
            end
          end else if (cls.store) begin
            mem_wr  = 1'b1;
            state_d = mem_ready ? StIf : StMem;
          end
        end
        StWb: begin
          reg_we     = 1'b1;
          reg_dst    = cls.rtype;
          mem_to_reg = cls.load;
          state_d    = StIf;
        end
        StHalt: state_d = StHalt;
        default: state_d = StIf;
      endcase
    end
    strobe = mem_rd || mem_wr;
    if (strobe && !mem_ready && (wdog_inc == WdW'(WAIT_MAX))) begin
      timeout = 1'b1;
      state_d = StHalt;
    end
    if ((state_d != state_q) || mem_ready) begin
      wdog_d = '0;
    end else if (strobe) begin
      wdog_d = wdog_inc;
    end else begin
      wdog_d = wdog_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIf;
      wdog_q   <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wdog_q   <= wdog_d;
      halted_q <= halted_q || (state_d == StHalt);
      fault_q  <= fault_q || timeout;
    end
  end

  assign halted    = halted_q;
  assign mem_fault = fault_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks instruction classes cycle by cycle against hand-derived
// expectations, plus illegal/halt, watchdog timeout and asynchronous reset mid-access.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_we, ab_we, alu_cache_we, mdr_we, pc_we, reg_we;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a, reg_dst, mem_to_reg, mem_rd, mem_wr;
  logic [2:0] alu_op, state;
  logic       illegal_op, halted, mem_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.WAIT_MAX(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .ir_we        (ir_we),
    .ab_we        (ab_we),
    .alu_cache_we (alu_cache_we),
    .mdr_we       (mdr_we),
    .pc_we        (pc_we),
    .reg_we       (reg_we),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .illegal_op   (illegal_op),
    .halted       (halted),
    .mem_fault    (mem_fault),
    .state        (state)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Zero-wait fetch cycle, then advance into ID.
  task automatic do_if(input string tag);
    mem_ready = 1'b1;
    #1;
    chk3({tag, "_if_state"}, state, 3'd0);
    chk1({tag, "_if_mem_rd"}, mem_rd, 1'b1);
    chk1({tag, "_if_ir_we"}, ir_we, 1'b1);
    chk1({tag, "_if_pc_we"}, pc_we, 1'b1);
    chk3({tag, "_if_pc_src"}, {1'b0, pc_src}, 3'd0);
    chk3({tag, "_if_src_b"}, {1'b0, alu_src_b}, 3'd1);
    tick();
  endtask

  // Checks the common ID outputs; caller advances the clock.
  task automatic do_id(input string tag);
    #1;
    chk3({tag, "_id_state"}, state, 3'd1);
    chk1({tag, "_id_ab_we"}, ab_we, 1'b1);
    chk1({tag, "_id_cache_we"}, alu_cache_we, 1'b1);
    chk3({tag, "_id_src_b"}, {1'b0, alu_src_b}, 3'd3);
    chk1({tag, "_id_pc_we"}, pc_we, 1'b0);
    chk1({tag, "_id_reg_we"}, reg_we, 1'b0);
  endtask

  logic [5:0] fn_tab [5];
  logic [2:0] aop_tab[5];
  logic [5:0] br_op  [4];
  logic       br_zero[4];
  logic       br_pcwe[4];

  initial begin
    fn_tab  = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    aop_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    br_op   = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    br_zero = '{1'b1, 1'b0, 1'b0, 1'b1};
    br_pcwe = '{1'b1, 1'b0, 1'b1, 1'b0};

    // Reset: strobes quiet while rst is high, mem_rd once released.
    #3;
    chk1("rst_mem_rd", mem_rd, 1'b0);
    chk3("rst_state", state, 3'd0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_fault", mem_fault, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk1("rel_mem_rd", mem_rd, 1'b1);
    chk1("rel_ir_we", ir_we, 1'b0);

    // R-type add: IF, ID, EXE, WB.
    opcode = 6'b000000;
    funct  = 6'b100000;
    do_if("add");
    do_id("add");
    tick();
    #1;
    chk3("add_exe_state", state, 3'd2);
    chk1("add_exe_src_a", alu_src_a, 1'b1);
    chk3("add_exe_src_b", {1'b0, alu_src_b}, 3'd0);
    chk3("add_exe_op", alu_op, 3'd0);
    chk1("add_exe_cache_we", alu_cache_we, 1'b1);
    chk1("add_exe_reg_we", reg_we, 1'b0);
    tick();
    #1;
    chk3("add_wb_state", state, 3'd4);
    chk1("add_wb_reg_we", reg_we, 1'b1);
    chk1("add_wb_reg_dst", reg_dst, 1'b1);
    chk1("add_wb_m2r", mem_to_reg, 1'b0);
    chk1("add_wb_cache_we", alu_cache_we, 1'b0);
    tick();
    #1;
    chk3("add_next_state", state, 3'd0);

    // Remaining R-type functs, including an unknown one that acts as add.
    for (int i = 0; i < 5; i++) begin
      funct = fn_tab[i];
      do_if($sformatf("rt%0d", i));
      do_id($sformatf("rt%0d", i));
      tick();
      #1;
      chk3($sformatf("rt%0d_exe_op", i), alu_op, aop_tab[i]);
      tick();
      #1;
      chk1($sformatf("rt%0d_wb_reg_we", i), reg_we, 1'b1);
      tick();
    end

    // addi and ori: immediate source, rt destination.
    opcode = 6'b001000;
    do_if("addi");
    do_id("addi");
    tick();
    #1;
    chk3("addi_exe_src_b", {1'b0, alu_src_b}, 3'd2);
    chk3("addi_exe_op", alu_op, 3'd0);
    tick();
    #1;
    chk3("addi_wb_state", state, 3'd4);
    chk1("addi_wb_reg_dst", reg_dst, 1'b0);
    tick();
    opcode = 6'b001101;
    do_if("ori");
    do_id("ori");
    tick();
    #1;
    chk3("ori_exe_op", alu_op, 3'd3);
    chk1("ori_exe_cache_we", alu_cache_we, 1'b1);
    tick();
    tick();

    // lw with three wait cycles in MEM.
    opcode = 6'b100011;
    do_if("lw");
    do_id("lw");
    tick();
    #1;
    chk3("lw_exe_state", state, 3'd2);
    chk3("lw_exe_src_b", {1'b0, alu_src_b}, 3'd2);
    chk1("lw_exe_mem_rd", mem_rd, 1'b0);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk3($sformatf("lw_wait%0d_state", i), state, 3'd3);
      chk1($sformatf("lw_wait%0d_mem_rd", i), mem_rd, 1'b1);
      chk1($sformatf("lw_wait%0d_mdr_we", i), mdr_we, 1'b0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk1("lw_rdy_mem_rd", mem_rd, 1'b1);
    chk1("lw_rdy_mdr_we", mdr_we, 1'b1);
    chk1("lw_rdy_mem_wr", mem_wr, 1'b0);
    tick();
    #1;
    chk3("lw_wb_state", state, 3'd4);
    chk1("lw_wb_m2r", mem_to_reg, 1'b1);
    chk1("lw_wb_reg_we", reg_we, 1'b1);
    chk1("lw_wb_reg_dst", reg_dst, 1'b0);
    chk1("lw_wb_mdr_we", mdr_we, 1'b0);
    tick();
    #1;
    chk3("lw_next_state", state, 3'd0);

    // beq/bne with both zero values.
    for (int i = 0; i < 4; i++) begin
      opcode = br_op[i];
      zero   = br_zero[i];
      do_if($sformatf("br%0d", i));
      do_id($sformatf("br%0d", i));
      tick();
      #1;
      chk3($sformatf("br%0d_exe_state", i), state, 3'd2);
      chk1($sformatf("br%0d_exe_pc_we", i), pc_we, br_pcwe[i]);
      chk3($sformatf("br%0d_exe_pc_src", i), {1'b0, pc_src}, 3'd1);
      chk3($sformatf("br%0d_exe_op", i), alu_op, 3'd1);
      tick();
      #1;
      chk3($sformatf("br%0d_next_state", i), state, 3'd0);
    end
    zero = 1'b0;

    // j
    opcode = 6'b000010;
    do_if("j");
    do_id("j");
    tick();
    #1;
    chk1("j_exe_pc_we", pc_we, 1'b1);
    chk3("j_exe_pc_src", {1'b0, pc_src}, 3'd2);
    tick();
    #1;
    chk3("j_next_state", state, 3'd0);

    // sw, zero-wait.
    opcode = 6'b101011;
    do_if("sw");
    do_id("sw");
    tick();
    #1;
    chk3("sw_exe_state", state, 3'd2);
    tick();
    #1;
    chk3("sw_mem_state", state, 3'd3);
    chk1("sw_mem_wr", mem_wr, 1'b1);
    chk1("sw_mem_rd", mem_rd, 1'b0);
    tick();
    #1;
    chk3("sw_next_state", state, 3'd0);

    // sw aborted by reset in the middle of a stalled MEM cycle.
    do_if("swr");
    do_id("swr");
    tick();
    #1;
    chk1("swr_exe_pc_we", pc_we, 1'b0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk1("swr_mem_wr", mem_wr, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk1("swr_rst_mem_wr", mem_wr, 1'b0);
    chk3("swr_rst_state", state, 3'd0);
    chk1("swr_rst_pc_we", pc_we, 1'b0);
    tick();
    #1;
    chk1("swr_rst2_pc_we", pc_we, 1'b0);
    chk1("swr_rst2_reg_we", reg_we, 1'b0);
    rst = 1'b0;
    #1;
    chk3("swr_rel_state", state, 3'd0);
    chk1("swr_rel_mem_rd", mem_rd, 1'b1);
    chk1("swr_rel_pc_we", pc_we, 1'b0);

    // Illegal opcode: one-cycle pulse in ID, back to IF.
    opcode = 6'b111110;
    do_if("ill");
    do_id("ill");
    chk1("ill_id_pulse", illegal_op, 1'b1);
    tick();
    #1;
    chk3("ill_next_state", state, 3'd0);
    chk1("ill_next_pulse", illegal_op, 1'b0);

    // halt: HALT state, everything quiet for 20 cycles even with mem_ready high.
    opcode = 6'b111111;
    do_if("hlt");
    do_id("hlt");
    chk1("hlt_id_illegal", illegal_op, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      #1;
      chk3($sformatf("hlt%0d_state", i), state, 3'd5);
      chk1($sformatf("hlt%0d_halted", i), halted, 1'b1);
      chk1($sformatf("hlt%0d_quiet", i),
           |{ir_we, ab_we, alu_cache_we, mdr_we, pc_we, reg_we, mem_rd, mem_wr, illegal_op},
           1'b0);
      chk1($sformatf("hlt%0d_fault", i), mem_fault, 1'b0);
      tick();
    end

    // Watchdog: fetch never acknowledged.
    rst = 1'b1;
    #1;
    chk1("wd_rst_halted", halted, 1'b0);
    tick();
    mem_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk3($sformatf("wd%0d_state", i), state, 3'd0);
      chk1($sformatf("wd%0d_mem_rd", i), mem_rd, 1'b1);
      chk1($sformatf("wd%0d_fault", i), mem_fault, 1'b0);
      tick();
    end
    #1;
    chk3("wd_to_state", state, 3'd5);
    chk1("wd_to_fault", mem_fault, 1'b1);
    chk1("wd_to_halted", halted, 1'b1);
    chk1("wd_to_mem_rd", mem_rd, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencer for the SC-CPU datapath. Walks each instruction through IF/ID/EXE/MEM/WB states and drives the load enables of the intermediate latches: IR, A/B operands, ALU result cache and memory data register. It also drives PC write, register-file write, ALU operand and op selects, and memory request strobes. Memory uses a ready handshake, guarded by a watchdog that halts the core on a stalled access.

## Interface
- WAIT_MAX, 15: maximum cycles a memory strobe is held without mem_ready before fault; counter width is clog2(WAIT_MAX+1).
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26], valid from ID onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, sampled in EXE.
- mem_ready  in  1  memory completes the current mem_rd/mem_wr this cycle.
- ir_we, ab_we, alu_cache_we, mdr_we, pc_we, reg_we  out  1 each  latch/register enables.
- pc_src  out  2  0 = ALU (PC+4), 1 = ALU cache (branch target), 2 = jump {PC[31:28], IR[25:0], 2'b00}.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = sext(imm), 3 = sext(imm)<<2.
- alu_op  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = write-back from MDR.
- mem_rd, mem_wr  out  1 each  memory strobes, held until mem_ready.
- illegal_op  out  1  one-cycle pulse in ID on an unknown opcode.
- halted  out  1  sticky; set by HALT opcode or memory timeout.
- mem_fault  out  1  sticky; set by watchdog timeout.
- state  out  3  current state encoding, for debug.

## Operation
- Opcodes:
  - R-type 000000: funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct is treated as add.
  - Others: addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, halt 111111.
- State register with async reset. Outputs are combinational from state, opcode, zero and mem_ready.
- IF: mem_rd=1, alu_src_a=0, alu_src_b=1, alu_op=add.
  - When mem_ready: ir_we=1, pc_we=1, pc_src=0, next ID.
  - Otherwise: stay in IF.
- ID: ab_we=1, alu_cache_we=1, alu_src_a=0, alu_src_b=3, alu_op=add (precomputes branch target).
  - halt: next HALT.
  - Unknown opcode: illegal_op=1, next IF (instruction acts as NOP).
  - All other opcodes: next EXE.
- EXE:
  - R-type: alu_src_a=1, alu_src_b=0, alu_op from funct, alu_cache_we=1, next WB.
  - addi: src_b=2, add, alu_cache_we=1, next WB.
  - ori: src_b=2, or, alu_cache_we=1, next WB (the datapath zero-extends).
  - lw/sw: src_b=2, add, alu_cache_we=1, next MEM.
  - beq/bne: src_a=1, src_b=0, sub, pc_src=1. pc_we = zero for beq, !zero for bne. Next IF.
  - j: pc_we=1, pc_src=2, next IF.
- MEM:
  - lw: mem_rd=1; on mem_ready, mdr_we=1 and next WB.
  - sw: mem_wr=1; on mem_ready, next IF.
- WB: reg_we=1.
  - R-type: reg_dst=1, mem_to_reg=0.
  - addi/ori: reg_dst=0, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1.
  - Next IF.
- HALT: all enables and strobes 0; remains until rst.
- Watchdog:
  - Counter clears whenever the state changes or mem_ready=1.
  - Increments each cycle a strobe is asserted without mem_ready.
  - When the count reaches WAIT_MAX with no ready: next HALT, mem_fault=1, halted=1. The strobe drops that same next cycle.

## Timing
- Reset: state=IF, halted=0, mem_fault=0, watchdog=0. All enables 0 except mem_rd=1, which is asserted from the first cycle after reset release.
- Cycles per instruction with zero-wait memory (mem_ready high in the cycle of the strobe):
  - R-type/addi/ori: 4.
  - lw: 5.
  - sw: 4.
  - beq/bne/j: 3.
  - illegal: 2.
  - halt: 2 to reach HALT.
- Each wait cycle adds 1 cycle in IF or MEM.
- Latch enables are single-cycle pulses, except the memory strobes, which are level-held until mem_ready.
- mem_rd and mem_wr are never high together.
- mem_ready outside IF/MEM, or with no strobe asserted, is ignored.
- rst mid-instruction: state returns to IF immediately, independent of clk. Strobes drop the same cycle. No partial pc_we or reg_we is issued afterwards.

## Structure
- Package mc_pkg holds:
  - State enum: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5.
  - Opcode and funct localparams.
  - alu_op, pc_src and alu_src_b codes.
- Sub-module mc_decode: purely combinational opcode/funct to instruction class (rtype, imm_arith, load, store, branch, jump, halt, illegal) plus R-type alu_op. The FSM instantiates it once.

## Test plan
- add (funct 100000), mem_ready tied high -> states IF,ID,EXE,WB in 4 cycles; reg_we=1 with reg_dst=1 in WB only; alu_cache_we in ID and EXE.
- lw with mem_ready delayed 3 cycles in MEM -> mem_rd held 4 cycles; mdr_we pulses exactly on the ready cycle; WB has mem_to_reg=1, reg_we=1; total 8 cycles.
- beq with zero=1, then with zero=0 -> pc_we=1 with pc_src=1 in EXE only when zero=1; bne gives the inverse; both return to IF after 3 cycles.
- opcode 111110 -> illegal_op pulses for 1 cycle in ID, next state IF; then halt 111111 -> HALT, halted=1, all outputs 0 for 20 cycles.
- mem_ready held low in IF with WAIT_MAX=15 -> after 15 strobe cycles state=HALT, mem_fault=1, mem_rd=0.
- rst asserted mid-MEM of sw -> mem_wr drops asynchronously; after release, state=IF and mem_rd=1; no pc_we was issued during the aborted instruction.
